// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 keyboard input stage.
// Frame FSM state encodings, the break-code value and frame bit counts.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_t;

    localparam logic [7:0] PS2_BREAK      = 8'hF0;
    localparam int         PS2_DATA_BITS  = 8;
    localparam int         PS2_FRAME_BITS = 11;

endpackage

// File: rtl/ps2_sync_filter.sv
// Two-flop synchroniser plus glitch filter for the PS/2 clock line.
// Emits a one-cycle registered pulse when the filtered level falls.
module ps2_sync_filter #(
    parameter int FILTER = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic pin,
    output logic fall
);

    localparam int CW = (FILTER > 1) ? $clog2(FILTER + 1) : 1;

    logic [1:0]    sync;
    logic          level;
    logic [CW-1:0] cnt;

    // cnt tracks how many consecutive samples disagree with the accepted level
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync  <= 2'b11;
            level <= 1'b1;
            cnt   <= '0;
            fall  <= 1'b0;
        end else begin
            sync <= {sync[0], pin};
            fall <= 1'b0;
            if (sync[1] == level) begin
                cnt <= '0;
            end else if (cnt == CW'(FILTER - 1)) begin
                level <= sync[1];
                cnt   <= '0;
                fall  <= level;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_key_buffer.sv
// PS/2 receiver: frame deserialiser, optional break-code filter and scancode FIFO.
// The FIFO head is presented on registered outputs; key_ack pops it.
module ps2_key_buffer
    import ps2_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int FILTER     = 4,
    parameter int TIMEOUT    = 5000,
    parameter bit DROP_BREAK = 1'b1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2_clock_pin,
    input  logic       ps2_data_pin,
    input  logic       key_ack,
    output logic       ps2_key_pressed,
    output logic [7:0] ps2_out,
    output logic       overflow,
    output logic       frame_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT + 1);

    logic          fall;
    logic [1:0]    data_sync;
    logic          data_bit;
    ps2_state_t    state;
    logic [2:0]    bitcnt;
    logic [7:0]    shreg;
    logic          par_bit;
    logic [TW-1:0] tcnt;
    logic          skip_next;

    logic          byte_good;
    logic          push_req;

    ps2_sync_filter #(.FILTER(FILTER)) u_clk_filt (
        .clock (clock),
        .reset (reset),
        .pin   (ps2_clock_pin),
        .fall  (fall)
    );

    assign data_bit  = data_sync[1];
    assign byte_good = fall && (state == ST_STOP) && data_bit && (^{shreg, par_bit});
    assign push_req  = byte_good && !(DROP_BREAK && (skip_next || shreg == PS2_BREAK));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            data_sync <= 2'b11;
            state     <= ST_IDLE;
            bitcnt    <= '0;
            shreg     <= '0;
            par_bit   <= 1'b0;
            tcnt      <= '0;
            skip_next <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            data_sync <= {data_sync[0], ps2_data_pin};
            frame_err <= 1'b0;
            tcnt      <= (state == ST_IDLE || fall) ? '0 : tcnt + 1'b1;
            if (state != ST_IDLE && !fall && tcnt == TW'(TIMEOUT - 1)) begin
                state     <= ST_IDLE;
                tcnt      <= '0;
                frame_err <= 1'b1;
            end else if (fall) begin
                case (state)
                    ST_IDLE: begin
                        if (!data_bit) begin
                            state  <= ST_DATA;
                            bitcnt <= '0;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                    ST_DATA: begin
                        shreg  <= {data_bit, shreg[7:1]};
                        bitcnt <= bitcnt + 1'b1;
                        if (bitcnt == 3'(PS2_DATA_BITS - 1))
                            state <= ST_PARITY;
                    end
                    ST_PARITY: begin
                        par_bit <= data_bit;
                        state   <= ST_STOP;
                    end
                    ST_STOP: begin
                        state <= ST_IDLE;
                        if (!byte_good)
                            frame_err <= 1'b1;
                        else if (DROP_BREAK)
                            skip_next <= skip_next ? 1'b0 : (shreg == PS2_BREAK);
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    // FIFO with one extra pointer bit so full and empty are distinguishable
    logic [7:0] mem [DEPTH];
    logic [AW:0] wptr, rptr, wptr_n, rptr_n;
    logic        full, empty, push, pop;
    logic [7:0]  head_n;

    assign empty  = (wptr == rptr);
    assign full   = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign pop    = key_ack && !empty;
    assign push   = push_req && (!full || pop);
    assign wptr_n = wptr + (AW+1)'(push);
    assign rptr_n = rptr + (AW+1)'(pop);

    // Next head bypasses the byte being written when it lands in the head slot
    always_comb begin
        head_n = 8'h00;
        if (wptr_n != rptr_n) begin
            if (push && wptr[AW-1:0] == rptr_n[AW-1:0])
                head_n = shreg;
            else
                head_n = mem[rptr_n[AW-1:0]];
        end
    end

    always_ff @(posedge clock) begin
        if (push)
            mem[wptr[AW-1:0]] <= shreg;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wptr            <= '0;
            rptr            <= '0;
            ps2_out         <= 8'h00;
            ps2_key_pressed <= 1'b0;
            overflow        <= 1'b0;
        end else begin
            wptr            <= wptr_n;
            rptr            <= rptr_n;
            ps2_out         <= head_n;
            ps2_key_pressed <= (wptr_n != rptr_n);
            if (push_req && full && !pop)
                overflow <= 1'b1;
        end
    end

endmodule

// File: doc/ps2_key_buffer.md
# ps2_key_buffer

Upstream input stage for the pipelined processor. It deserialises the raw PS/2 keyboard line (device clock and data), checks each 11-bit frame, and queues valid scancodes in a small FIFO. The processor sees the head of the queue on `ps2_out`, qualified by `ps2_key_pressed`, and acknowledges with `key_ack`. The block optionally discards break-code sequences, so the core only sees make codes.

## Interface
- `DEPTH`, 8: FIFO entries; must be a power of 2, minimum 2.
- `FILTER`, 4: consecutive identical synchronised samples required before a PS/2 clock level is accepted.
- `TIMEOUT`, 5000: system clocks without a PS/2 falling edge before a partial frame is abandoned.
- `DROP_BREAK`, 1: when 1, byte 0xF0 and the byte that follows it are not queued.

Ports:
- `clock` in 1: system clock; all state changes on its rising edge.
- `reset` in 1: asynchronous, active-high.
- `ps2_clock_pin` in 1: raw PS/2 clock, asynchronous to `clock`.
- `ps2_data_pin` in 1: raw PS/2 data, asynchronous to `clock`.
- `key_ack` in 1: pops the head entry.
- `ps2_key_pressed` out 1: FIFO non-empty.
- `ps2_out` out 8: head scancode; 0x00 when empty.
- `overflow` out 1: sticky; cleared only by reset.
- `frame_err` out 1: one-cycle pulse on a parity, start or stop error, or on a timeout.

## Operation
- **Input conditioning.**
  - Both pins pass through 2-flop synchronisers.
  - The clock filter updates its stable level only after `FILTER` consecutive equal samples.
  - A falling edge of the filtered clock is `fall`. The data bit is the synchronised data sampled in the `fall` cycle.
- **Frame FSM states:** IDLE, DATA, PARITY, STOP.
  - IDLE: on `fall` with data=0, go to DATA and set bitcnt=0. On `fall` with data=1, pulse `frame_err` and stay in IDLE.
  - DATA: on each `fall`, shift the bit in LSB-first. After the 8th bit, go to PARITY.
  - PARITY: on `fall`, store the bit and go to STOP.
  - STOP: on `fall`, return to IDLE. The byte is good if stop=1 and XOR(data, parity)=1 (odd parity). Otherwise pulse `frame_err`.
  - Timeout: outside IDLE, a counter is cleared on every `fall`. When it reaches `TIMEOUT`, the FSM returns to IDLE, pulses `frame_err`, and discards the partial byte.
- **Break filter** (`DROP_BREAK`=1): a good 0xF0 sets `skip_next` and is not queued. The next good byte clears `skip_next` and is not queued. A bad frame does not change `skip_next`.
- **FIFO.**
  - Read and write pointers are log2(`DEPTH`)+1 bits wide, so full and empty are distinguished by the MSB.
  - Push: a good, unfiltered byte. If the FIFO is full and there is no pop that cycle, the byte is dropped and `overflow` is set.
  - Pop: `key_ack` while non-empty. `key_ack` while empty is ignored.
  - Simultaneous push and pop when full: both succeed and the count is unchanged.
  - Simultaneous push and pop when empty: the push succeeds and the pop is ignored.
  - Pointers wrap modulo 2·`DEPTH`.
- **Reset.**
  - Outputs: `ps2_key_pressed`=0, `ps2_out`=0x00, `overflow`=0, `frame_err`=0.
  - State: FSM=IDLE, pointers=0, `skip_next`=0, synchronisers and filter set to 1 (idle bus).
  - Reset during a frame discards it. The remaining bits of that frame produce a start error or a timeout, never a push.

## Timing
- Pin to `fall`: 2 synchroniser cycles plus `FILTER` cycles.
- The push is registered at the clock edge ending the stop-bit `fall` cycle. `ps2_key_pressed` and `ps2_out` are valid from that edge; latency is 1 cycle after `fall`.
- Pop: `key_ack` high at edge N advances the head. The new `ps2_out` and `ps2_key_pressed` are valid after edge N.
- `ps2_out` and `ps2_key_pressed` are registered outputs with no combinational path from `key_ack`.
- `frame_err` is high exactly one cycle, in the cycle after the error-detecting `fall` or after the timeout is reached.

## Structure
- Shared package `ps2_pkg`:
  - FSM state encodings.
  - `PS2_BREAK`=8'hF0.
  - Frame bit counts.
- Sub-module `ps2_sync_filter` (synchronisers, glitch filter, `fall` generation), instantiated once for the clock line. The data line uses only the synchroniser.
- The FIFO is inline, with registered head read.

## Test plan
- **Single good frame, 0x1C (odd parity bit 0):** `ps2_key_pressed` rises 1 cycle after the stop `fall`; `ps2_out`=0x1C; `key_ack` pulse → pressed=0, `ps2_out`=0x00.
- **Break filtering:** frames 0x1C, 0xF0, 0x1C, 0x32 with `DROP_BREAK`=1 → FIFO holds 0x1C then 0x32. With `DROP_BREAK`=0 → all four bytes are queued.
- **Parity error:** 0x1C sent with parity bit 1 → `frame_err` one-cycle pulse, nothing queued; a following good 0x2D is queued.
- **Overflow and wrap:**
  - 9 frames into `DEPTH`=8 with no ack → 8 entries held, `overflow`=1, 9th byte lost.
  - Drain all entries and send 3 more → 0x01…0x03 read in order across the pointer wrap.
- **Full push + pop same cycle:** count stays 8 and the order is preserved.
- **Timeout and mid-frame reset:**
  - Stop the PS/2 clock after 4 data bits → `frame_err` at `TIMEOUT` cycles, FSM back in IDLE.
  - Assert `reset` mid-frame → all outputs 0, no byte queued.
